// File: rtl/ble_ram_arbiter.sv
// Shares one wishbone RAM port between a CPU master and a UART RX byte stream.
// RX bytes are buffered in a small FIFO and written one per word into a ring buffer in RAM.
module ble_ram_arbiter #(
  parameter logic [31:0] ADR_LL     = 32'h00C00000,
  parameter logic [31:0] ADR_UL     = 32'h00C10000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  input  logic        i_cpu_we,
  input  logic [3:0]  i_cpu_sel,
  input  logic [31:0] i_cpu_dat,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_done,
  output logic [31:0] o_ram_adr,
  output logic        o_ram_cyc,
  output logic        o_ram_we,
  output logic [3:0]  o_ram_sel,
  output logic [31:0] o_ram_dat,
  input  logic [31:0] i_ram_rdt,
  input  logic        i_ram_ack,
  output logic [31:0] o_wr_ptr,
  output logic        o_overflow,
  input  logic        i_ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_GNT_RX, S_GNT_CPU} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_last_rx;
  logic [7:0]      r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_idx;
  logic [AW-1:0]   r_wr_idx;
  logic [AW:0]     r_count;
  logic [31:0]     r_wr_ptr;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_event;
  logic [7:0]      w_fifo_head;
  logic [32:0]     w_ptr_inc;
  logic [31:0]     w_ptr_next;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = (r_state == S_GNT_RX) && i_ram_ack && !w_empty;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign w_push      = i_rx_done && (!w_full || w_pop);
  assign w_ovf_event = i_rx_done && w_full && !w_pop;
  assign w_fifo_head = r_fifo_mem[r_rd_idx];

  assign w_ptr_inc   = {1'b0, r_wr_ptr} + 33'd4;
  assign w_ptr_next  = (w_ptr_inc >= {1'b0, ADR_UL}) ? ADR_LL : w_ptr_inc[31:0];

  always_ff @(posedge i_wb_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_idx] <= i_rx_dat;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_count    <= '0;
      r_wr_ptr   <= ADR_LL;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_idx <= r_wr_idx + AW'(1);
      end
      if (w_pop) begin
        r_rd_idx <= r_rd_idx + AW'(1);
        r_wr_ptr <= w_ptr_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_ovf_event) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // State register plus the round-robin marker of the last grant taken.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_state   <= S_IDLE;
      r_last_rx <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_state_next == S_GNT_RX) begin
        r_last_rx <= 1'b1;
      end else if (r_state == S_IDLE && w_state_next == S_GNT_CPU) begin
        r_last_rx <= 1'b0;
      end
    end
  end

  // An incoming byte counts as pending so an idle arbiter grants RX on the very next cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if ((!w_empty || i_rx_done) && !(r_last_rx && i_cpu_cyc)) begin
          w_state_next = S_GNT_RX;
        end else if (i_cpu_cyc) begin
          w_state_next = S_GNT_CPU;
        end
      end
      S_GNT_RX: begin
        if (i_ram_ack) begin
          w_state_next = S_IDLE;
        end
      end
      S_GNT_CPU: begin
        if (i_ram_ack || !i_cpu_cyc) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ram_adr = 32'h0;
    o_ram_cyc = 1'b0;
    o_ram_we  = 1'b0;
    o_ram_sel = 4'h0;
    o_ram_dat = 32'h0;
    o_cpu_ack = 1'b0;
    case (r_state)
      S_GNT_RX: begin
        o_ram_adr = r_wr_ptr;
        o_ram_cyc = 1'b1;
        o_ram_we  = 1'b1;
        o_ram_sel = 4'hF;
        o_ram_dat = {24'h0, w_fifo_head};
      end
      S_GNT_CPU: begin
        o_ram_adr = i_cpu_adr;
        o_ram_cyc = i_cpu_cyc;
        o_ram_we  = i_cpu_we;
        o_ram_sel = i_cpu_sel;
        o_ram_dat = i_cpu_dat;
        o_cpu_ack = i_ram_ack;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdt  = i_ram_rdt;
  assign o_wr_ptr   = r_wr_ptr;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_ble_ram_arbiter.sv
// Self-checking bench for ble_ram_arbiter: directed arbitration scenarios plus a
// queue-based model of the RX ring that checks every RX RAM write, o_wr_ptr and o_overflow.
module tb_ble_ram_arbiter;
  localparam logic [31:0] LL    = 32'h00C00000;
  localparam logic [31:0] UL    = 32'h00C10000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_adr = '0;
  logic        cpu_cyc = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_dat = '0;
  logic [31:0] cpu_rdt;
  logic        cpu_ack;
  logic [7:0]  rx_dat = '0;
  logic        rx_done = 1'b0;
  logic [31:0] ram_adr;
  logic        ram_cyc;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_dat;
  logic [31:0] ram_rdt = '0;
  logic        ram_ack = 1'b0;
  logic [31:0] wr_ptr;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  always #5 clk = ~clk;

  ble_ram_arbiter #(.ADR_LL(LL), .ADR_UL(UL), .FIFO_DEPTH(DEPTH)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_cpu_adr(cpu_adr), .i_cpu_cyc(cpu_cyc), .i_cpu_we(cpu_we),
    .i_cpu_sel(cpu_sel), .i_cpu_dat(cpu_dat),
    .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .i_rx_dat(rx_dat), .i_rx_done(rx_done),
    .o_ram_adr(ram_adr), .o_ram_cyc(ram_cyc), .o_ram_we(ram_we),
    .o_ram_sel(ram_sel), .o_ram_dat(ram_dat),
    .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack),
    .o_wr_ptr(wr_ptr), .o_overflow(overflow), .i_ovf_clr(ovf_clr)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rx_wr = 0;
  logic [7:0]  m_q[$];
  logic [31:0] m_ptr = LL;
  logic        m_ovf = 1'b0;
  logic        mon_cpu_acked = 1'b0;

  // Reference model: evaluated mid-cycle, it predicts what the coming rising edge does.
  always @(negedge clk) begin
    logic        rxw;
    logic        full;
    logic        ev;
    logic [31:0] exp_d;
    if (!rst_n) begin
      m_q.delete();
      m_ptr = LL;
      m_ovf = 1'b0;
      mon_cpu_acked = 1'b0;
    end else begin
      n_cmp++;
      if (wr_ptr !== m_ptr) begin
        n_err++;
        $display("FAIL wr_ptr: got %h expected %h", wr_ptr, m_ptr);
      end
      n_cmp++;
      if (overflow !== m_ovf) begin
        n_err++;
        $display("FAIL overflow_flag: got %b expected %b", overflow, m_ovf);
      end
      mon_cpu_acked = cpu_ack;
      rxw  = ram_cyc && ram_we && ram_ack && !cpu_ack;
      full = (m_q.size() >= DEPTH);
      if (rxw) begin
        n_rx_wr++;
        n_cmp++;
        if (m_q.size() == 0) begin
          n_err++;
          $display("FAIL rx_write_spurious: adr %h dat %h with nothing pending", ram_adr, ram_dat);
        end else begin
          exp_d = {24'h0, m_q[0]};
          if (ram_adr !== m_ptr || ram_dat !== exp_d || ram_sel !== 4'hF) begin
            n_err++;
            $display("FAIL rx_write: got adr %h dat %h sel %h expected adr %h dat %h sel f",
                     ram_adr, ram_dat, ram_sel, m_ptr, exp_d);
          end
          void'(m_q.pop_front());
        end
        m_ptr = (m_ptr + 32'd4 >= UL) ? LL : m_ptr + 32'd4;
      end
      ev = rx_done && full && !rxw;
      if (rx_done && !ev) m_q.push_back(rx_dat);
      if (ev) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_adr = 32'hDEADBEEC; cpu_sel = 4'hF;
    cpu_dat = 32'h12345678; ram_ack = 1'b1; rx_done = 1'b1; rx_dat = 8'h3C;
    repeat (3) tick();
    n_cmp++;
    if (ram_cyc !== 1'b0 || ram_we !== 1'b0 || ram_adr !== 32'h0 || ram_sel !== 4'h0 || ram_dat !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ram_port: got cyc %b we %b adr %h sel %h dat %h expected all zero",
               ram_cyc, ram_we, ram_adr, ram_sel, ram_dat);
    end
    n_cmp++;
    if (cpu_ack !== 1'b0 || wr_ptr !== LL || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got ack %b ptr %h ovf %b expected 0 %h 0", cpu_ack, wr_ptr, overflow, LL);
    end
    cpu_cyc = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_sel = '0; cpu_dat = '0;
    ram_ack = 1'b0; rx_done = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    rx_dat = 8'hA5; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'hF || ram_adr !== 32'h00C00000 || ram_dat !== 32'h000000A5) begin
      n_err++;
      $display("FAIL single_write: got cyc %b we %b sel %h adr %h dat %h expected 1 1 f 00c00000 000000a5",
               ram_cyc, ram_we, ram_sel, ram_adr, ram_dat);
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    #1;
    n_cmp++;
    if (wr_ptr !== 32'h00C00004 || ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL single_ptr: got ptr %h cyc %b expected 00c00004 0", wr_ptr, ram_cyc);
    end
    $display("test_single: wrote a5 at 00c00000");
  endtask

  task automatic test_priority();
    logic [7:0] b;
    b = 8'($urandom);
    cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h200; cpu_sel = 4'hF;
    tick();
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b0 || ram_adr !== 32'h200) begin
      n_err++;
      $display("FAIL prio_cpu_first: got cyc %b we %b adr %h expected 1 0 00000200", ram_cyc, ram_we, ram_adr);
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0; cpu_adr = 32'h204; rx_dat = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_adr !== m_ptr || ram_dat !== {24'h0, b}) begin
      n_err++;
      $display("FAIL prio_rx_after_cpu: got we %b adr %h dat %h expected 1 %h %h", ram_we, ram_adr, ram_dat, m_ptr, {24'h0, b});
    end
    ram_ack = 1'b1;
    #1;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL prio_no_cpu_ack_in_rx: got %b expected 0", cpu_ack);
    end
    tick();
    ram_ack = 1'b0;
    tick();
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b0 || ram_adr !== 32'h204) begin
      n_err++;
      $display("FAIL prio_cpu_after_rx: got cyc %b we %b adr %h expected 1 0 00000204", ram_cyc, ram_we, ram_adr);
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0; cpu_cyc = 1'b0;
    tick();
    $display("test_priority: cpu, rx, cpu grants");
  endtask

  task automatic test_order();
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [31:0] rd;
    b1 = 8'($urandom); b2 = 8'($urandom); rd = $urandom;
    rx_dat = b1; rx_done = 1'b1;
    tick();
    rx_dat = b2;
    tick();
    rx_done = 1'b0; cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h00000100; cpu_sel = 4'hF;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_adr !== m_ptr || ram_dat !== {24'h0, b1} || cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL order_rx1: got we %b adr %h dat %h ack %b expected 1 %h %h 0", ram_we, ram_adr, ram_dat, cpu_ack, m_ptr, {24'h0, b1});
    end
    ram_ack = 1'b1;
    #1;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL order_ack_rx1: got cpu_ack %b expected 0", cpu_ack);
    end
    tick();
    ram_ack = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL order_idle1: got cyc %b expected 0", ram_cyc);
    end
    tick();
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b0 || ram_adr !== 32'h00000100) begin
      n_err++;
      $display("FAIL order_cpu: got cyc %b we %b adr %h expected 1 0 00000100", ram_cyc, ram_we, ram_adr);
    end
    ram_ack = 1'b1; ram_rdt = rd;
    #1;
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_rdt !== rd) begin
      n_err++;
      $display("FAIL order_cpu_ack: got ack %b rdt %h expected 1 %h", cpu_ack, cpu_rdt, rd);
    end
    tick();
    ram_ack = 1'b0; cpu_cyc = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0 || cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL order_idle2: got cyc %b ack %b expected 0 0", ram_cyc, cpu_ack);
    end
    tick();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_dat !== {24'h0, b2}) begin
      n_err++;
      $display("FAIL order_rx2: got we %b dat %h expected 1 %h", ram_we, ram_dat, {24'h0, b2});
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    tick();
    $display("test_order: rx %h, cpu read 00000100, rx %h", b1, b2);
  endtask

  task automatic test_overflow();
    int base;
    for (int i = 0; i < 6; i++) begin
      rx_dat = 8'($urandom); rx_done = 1'b1;
      tick();
    end
    rx_done = 1'b0;
    #1;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    rx_done = 1'b1; ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0; ovf_clr = 1'b0;
    #1;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_precedence: got %b expected 1", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    base = n_rx_wr;
    ram_ack = 1'b1;
    repeat (12) tick();
    ram_ack = 1'b0;
    #1;
    n_cmp++;
    if (n_rx_wr - base !== 4 || ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_stored: got %0d writes cyc %b expected 4 writes cyc 0", n_rx_wr - base, ram_cyc);
    end
    $display("test_overflow: 7 pulses into depth %0d, %0d bytes written", DEPTH, n_rx_wr - base);
  endtask

  task automatic test_abort();
    logic [7:0] b;
    b = 8'($urandom);
    cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h300; cpu_sel = 4'h3; cpu_dat = $urandom;
    tick();
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'h3 || ram_dat !== cpu_dat) begin
      n_err++;
      $display("FAIL abort_pass: got cyc %b we %b sel %h dat %h expected 1 1 3 %h", ram_cyc, ram_we, ram_sel, ram_dat, cpu_dat);
    end
    rx_dat = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; cpu_cyc = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0 || cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drop: got cyc %b ack %b expected 0 0", ram_cyc, cpu_ack);
    end
    tick();
    ram_ack = 1'b1;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0 || cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got cyc %b ack %b expected 0 0", ram_cyc, cpu_ack);
    end
    tick();
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_we !== 1'b1 || ram_dat !== {24'h0, b} || cpu_ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_rx_next: got cyc %b we %b dat %h ack %b expected 1 1 %h 0", ram_cyc, ram_we, ram_dat, cpu_ack, {24'h0, b});
    end
    tick();
    ram_ack = 1'b0;
    tick();
    $display("test_abort: cpu write aborted, rx %h served", b);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rx_done = ($urandom_range(0, 2) == 0);
      rx_dat  = 8'($urandom);
      ram_ack = $urandom_range(0, 1) == 1;
      ram_rdt = $urandom;
      ovf_clr = ($urandom_range(0, 19) == 0);
      if (cpu_cyc) begin
        if (mon_cpu_acked || $urandom_range(0, 15) == 0) cpu_cyc = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_cyc = 1'b1; cpu_we = $urandom_range(0, 1) == 1;
        cpu_adr = $urandom & 32'hFFFF_FFFC; cpu_sel = 4'($urandom); cpu_dat = $urandom;
      end
      #1;
      n_cmp++;
      if (cpu_rdt !== ram_rdt || (cpu_ack && !ram_ack)) begin
        n_err++;
        $display("FAIL rand_cpu_rdt: got rdt %h ack %b expected rdt %h ack<=%b", cpu_rdt, cpu_ack, ram_rdt, ram_ack);
      end
      if (cpu_ack) begin
        n_cmp++;
        if (ram_adr !== cpu_adr || ram_dat !== cpu_dat || ram_sel !== cpu_sel || ram_we !== cpu_we) begin
          n_err++;
          $display("FAIL rand_cpu_pass: got adr %h dat %h sel %h we %b expected %h %h %h %b",
                   ram_adr, ram_dat, ram_sel, ram_we, cpu_adr, cpu_dat, cpu_sel, cpu_we);
        end
      end
      tick();
    end
    cpu_cyc = 1'b0; rx_done = 1'b0; ovf_clr = 1'b1; ram_ack = 1'b1;
    repeat (20) tick();
    ram_ack = 1'b0; ovf_clr = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain: got cyc %b expected 0", ram_cyc);
    end
    $display("test_random: 800 cycles, %0d rx writes so far", n_rx_wr);
  endtask

  task automatic test_wrap();
    int it;
    logic [7:0] b;
    it = 0;
    ram_ack = 1'b1;
    while (m_ptr != 32'h00C0FFFC && it < 20000) begin
      rx_dat = 8'($urandom); rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
      it++;
    end
    ram_ack = 1'b0;
    if (m_ptr != 32'h00C0FFFC) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_fill_timeout: got ptr %h expected 00c0fffc", m_ptr);
    end
    b = 8'($urandom);
    rx_dat = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_adr !== 32'h00C0FFFC || ram_dat !== {24'h0, b}) begin
      n_err++;
      $display("FAIL wrap_write: got cyc %b adr %h dat %h expected 1 00c0fffc %h", ram_cyc, ram_adr, ram_dat, {24'h0, b});
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    #1;
    n_cmp++;
    if (wr_ptr !== 32'h00C00000) begin
      n_err++;
      $display("FAIL wrap_ptr: got %h expected 00c00000", wr_ptr);
    end
    $display("test_wrap: wrote %h at 00c0fffc, pointer wrapped", b);
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      rx_dat = 8'($urandom); rx_done = 1'b1;
      tick();
    end
    rx_done = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got cyc %b expected 0", ram_cyc);
    end
    ram_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (wr_ptr !== LL || overflow !== 1'b0 || ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_release: got ptr %h ovf %b cyc %b expected %h 0 0", wr_ptr, overflow, ram_cyc, LL);
    end
    base = n_rx_wr;
    repeat (3) tick();
    n_cmp++;
    if (ram_cyc !== 1'b0 || n_rx_wr !== base) begin
      n_err++;
      $display("FAIL rstmid_empty: got cyc %b writes %0d expected 0 0", ram_cyc, n_rx_wr - base);
    end
    ram_ack = 1'b0;
    b = 8'($urandom);
    rx_dat = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    #1;
    n_cmp++;
    if (ram_cyc !== 1'b1 || ram_adr !== LL || ram_dat !== {24'h0, b}) begin
      n_err++;
      $display("FAIL rstmid_first: got cyc %b adr %h dat %h expected 1 %h %h", ram_cyc, ram_adr, ram_dat, LL, {24'h0, b});
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (n_rx_wr - base !== 1 || ram_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d writes cyc %b expected 1 0", n_rx_wr - base, ram_cyc);
    end
    $display("test_reset_mid: reset during rx grant, fifo and pointer cleared");
  endtask

  initial begin
    #5ms;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_order();
    test_overflow();
    test_abort();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
